// File: rtl/cache_pkg.sv
// Shared definitions for the cache controller: FSM encoding and default address layout.
package cache_pkg;

    localparam int unsigned ST_W = 3;
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_LOOKUP   = 3'd1;
    localparam logic [2:0] ST_REFILL   = 3'd2;
    localparam logic [2:0] ST_WTHRU    = 3'd3;
    localparam logic [2:0] ST_UNCACHED = 3'd4;
    localparam logic [2:0] ST_FAULT    = 3'd5;

    // Default physical address layout: {tag[23:11], index[10:7], offset[6:0]}
    localparam int unsigned ADDR_W            = 24;
    localparam int unsigned ADDR_OFFSET_W     = 7;
    localparam int unsigned ADDR_OFFSET_LSB   = 0;
    localparam int unsigned ADDR_INDEX_W      = 4;
    localparam int unsigned ADDR_INDEX_LSB    = 7;
    localparam int unsigned ADDR_TAG_W        = 13;
    localparam int unsigned ADDR_TAG_LSB      = 11;
    localparam int unsigned ADDR_UNCACHED_BIT = 23;

endpackage

// File: rtl/cache_tag_ram.sv
// Tag/valid store: combinational read, synchronous write, single-cycle clear of all valid bits.
module cache_tag_ram
    import cache_pkg::*;
#(
    parameter int unsigned LINES = 16,
    parameter int unsigned IDX_W = 4,
    parameter int unsigned TAG_W = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_all,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic             wr_valid,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [TAG_W-1:0] rd_tag_c,
    output logic             rd_valid_c
);

    logic [TAG_W-1:0] tag_mem [LINES];
    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] valid_d;

    always_comb begin
        valid_d = valid_q;
        if (clr_all) begin
            valid_d = '0;
        end else if (wr_en) begin
            valid_d[wr_idx] = wr_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tags are not reset; valid gates their use.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx] <= wr_tag;
        end
    end

    assign rd_tag_c   = tag_mem[rd_idx];
    assign rd_valid_c = valid_q[rd_idx];

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller with an uncached region.
// Define CACHE_FLUSH_EN to make the flush input clear all valid bits (otherwise it is ignored).
module cache_ctrl
    import cache_pkg::*;
#(
    parameter int unsigned BUS_WIDTH = 8,
    parameter int unsigned BUS_ADDR  = ADDR_W,
    parameter int unsigned LINE_SIZE = 1 << ADDR_OFFSET_W,
    parameter int unsigned LINES     = 1 << ADDR_INDEX_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cpu_req,
    input  logic                         cpu_we,
    input  logic [BUS_ADDR-1:0]          cpu_addr,
    input  logic [BUS_WIDTH-1:0]         cpu_wdata,
    output logic [BUS_WIDTH-1:0]         cpu_rdata,
    output logic                         cpu_ready,
    output logic                         cpu_err,
    input  logic                         flush,
    output logic                         write_through_req,
    output logic                         read_req,
    output logic                         read_line_req,
    output logic [BUS_ADDR-1:0]          pa,
    output logic [BUS_WIDTH-1:0]         wt_data,
    input  logic [BUS_WIDTH-1:0]         line_data,
    input  logic [$clog2(LINE_SIZE)-1:0] addr_count,
    input  logic                         line_write,
    input  logic                         cache_entry_refill,
    input  logic                         trans_rdy,
    input  logic                         bus_error
);

    localparam int unsigned OFF_W   = $clog2(LINE_SIZE);
    localparam int unsigned IDX_W   = $clog2(LINES);
    localparam int unsigned TAG_W   = BUS_ADDR - OFF_W - IDX_W;
    localparam int unsigned UNC_BIT = BUS_ADDR - 1;
    localparam int unsigned DEPTH   = LINES * LINE_SIZE;

    logic [ST_W-1:0]      state_q, state_d;
    logic [BUS_ADDR-1:0]  addr_q, addr_d;
    logic                 we_q, we_d;
    logic [BUS_WIDTH-1:0] wdata_q, wdata_d;
    logic [BUS_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
    logic                 cpu_ready_q, cpu_ready_d;
    logic                 cpu_err_q, cpu_err_d;
    logic                 wtr_q, wtr_d;
    logic                 rr_q, rr_d;
    logic                 rlr_q, rlr_d;
    logic [BUS_ADDR-1:0]  pa_q, pa_d;
    logic [BUS_WIDTH-1:0] wt_data_q, wt_data_d;

    logic [OFF_W-1:0]       off_c;
    logic [IDX_W-1:0]       idx_c;
    logic [TAG_W-1:0]       tag_c;
    logic                   uncached_c;
    logic                   hit_c;
    logic                   flush_now_c;
    logic [TAG_W-1:0]       rd_tag_c;
    logic                   rd_valid_c;
    logic                   tag_wr_en_c;
    logic                   tag_wr_valid_c;
    logic                   clr_all_c;
    logic                   mem_we_c;
    logic [IDX_W+OFF_W-1:0] mem_waddr_c;
    logic [BUS_WIDTH-1:0]   mem_wdata_c;
    logic [BUS_WIDTH-1:0]   mem_rdata_c;

    logic [BUS_WIDTH-1:0] data_mem [DEPTH];

    assign off_c       = addr_q[OFF_W-1:0];
    assign idx_c       = addr_q[OFF_W +: IDX_W];
    assign tag_c       = addr_q[OFF_W+IDX_W +: TAG_W];
    assign uncached_c  = addr_q[UNC_BIT];
    assign hit_c       = rd_valid_c && (rd_tag_c == tag_c);
    assign mem_rdata_c = data_mem[{idx_c, off_c}];

`ifdef CACHE_FLUSH_EN
    logic flush_pend_q, flush_pend_d;

    // A flush seen while busy is remembered and applied once back in IDLE.
    always_comb begin
        flush_now_c  = (state_q == ST_IDLE) && (flush || flush_pend_q);
        flush_pend_d = flush_pend_q;
        if (flush_now_c) begin
            flush_pend_d = 1'b0;
        end else if (flush) begin
            flush_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flush_pend_q <= 1'b0;
        end else begin
            flush_pend_q <= flush_pend_d;
        end
    end
`else
    logic unused_flush;
    assign unused_flush = flush;
    assign flush_now_c  = 1'b0;
`endif

    cache_tag_ram #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_tag_ram (
        .clk        (clk),
        .rst        (rst),
        .clr_all    (clr_all_c),
        .wr_en      (tag_wr_en_c),
        .wr_idx     (idx_c),
        .wr_tag     (tag_c),
        .wr_valid   (tag_wr_valid_c),
        .rd_idx     (idx_c),
        .rd_tag_c   (rd_tag_c),
        .rd_valid_c (rd_valid_c)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        we_d           = we_q;
        wdata_d        = wdata_q;
        cpu_rdata_d    = cpu_rdata_q;
        cpu_ready_d    = 1'b0;
        cpu_err_d      = 1'b0;
        pa_d           = pa_q;
        wt_data_d      = wt_data_q;
        tag_wr_en_c    = 1'b0;
        tag_wr_valid_c = 1'b0;
        clr_all_c      = 1'b0;
        mem_we_c       = 1'b0;
        mem_waddr_c    = {idx_c, off_c};
        mem_wdata_c    = wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (flush_now_c) begin
                    clr_all_c = 1'b1;
                end else if (cpu_req) begin
                    addr_d  = cpu_addr;
                    we_d    = cpu_we;
                    wdata_d = cpu_wdata;
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (uncached_c) begin
                    state_d = ST_UNCACHED;
                end else if (we_q) begin
                    mem_we_c = hit_c;
                    state_d  = ST_WTHRU;
                end else if (hit_c) begin
                    cpu_rdata_d = mem_rdata_c;
                    cpu_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    // Invalidate on entry so an aborted refill never leaves a stale line.
                    tag_wr_en_c = 1'b1;
                    state_d     = ST_REFILL;
                end
            end
            ST_REFILL: begin
                if (bus_error) begin
                    cpu_ready_d = 1'b1;
                    cpu_err_d   = 1'b1;
                    state_d     = ST_FAULT;
                end else begin
                    mem_we_c    = line_write;
                    mem_waddr_c = {idx_c, addr_count};
                    mem_wdata_c = line_data;
                    if (cache_entry_refill) begin
                        tag_wr_en_c    = 1'b1;
                        tag_wr_valid_c = 1'b1;
                        state_d        = ST_LOOKUP;
                    end
                end
            end
            ST_WTHRU, ST_UNCACHED: begin
                if (bus_error) begin
                    cpu_ready_d = 1'b1;
                    cpu_err_d   = 1'b1;
                    state_d     = ST_FAULT;
                end else if (trans_rdy) begin
                    if (state_q == ST_UNCACHED && !we_q) begin
                        cpu_rdata_d = line_data;
                    end
                    cpu_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            ST_FAULT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Bus requests follow the next state so they are high exactly while in that state.
        rlr_d = (state_d == ST_REFILL);
        rr_d  = (state_d == ST_UNCACHED) && !we_d;
        wtr_d = (state_d == ST_WTHRU) || ((state_d == ST_UNCACHED) && we_d);
        if (rlr_d) begin
            pa_d = {tag_c, idx_c, {OFF_W{1'b0}}};
        end else if (rr_d || wtr_d) begin
            pa_d = addr_q;
        end
        if (wtr_d) begin
            wt_data_d = wdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            cpu_ready_q <= 1'b0;
            cpu_err_q   <= 1'b0;
            wtr_q       <= 1'b0;
            rr_q        <= 1'b0;
            rlr_q       <= 1'b0;
            pa_q        <= '0;
            wt_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            cpu_ready_q <= cpu_ready_d;
            cpu_err_q   <= cpu_err_d;
            wtr_q       <= wtr_d;
            rr_q        <= rr_d;
            rlr_q       <= rlr_d;
            pa_q        <= pa_d;
            wt_data_q   <= wt_data_d;
        end
    end

    // Data array is not reset.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            data_mem[mem_waddr_c] <= mem_wdata_c;
        end
    end

    assign cpu_rdata         = cpu_rdata_q;
    assign cpu_ready         = cpu_ready_q;
    assign cpu_err           = cpu_err_q;
    assign write_through_req = wtr_q;
    assign read_req          = rr_q;
    assign read_line_req     = rlr_q;
    assign pa                = pa_q;
    assign wt_data           = wt_data_q;

endmodule

// File: doc/cache_ctrl.md
CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 Parameters (name, default, meaning): BUS_WIDTH, 8, data width; BUS_ADDR, 24, physical address width; LINE_SIZE, 128, beats per line; LINES, 16, direct-mapped line count.
REQ-002 clk  in  1  clock; rst  in  1  synchronous, active-high reset.
REQ-003 cpu_req  in  1  access request; cpu_we  in  1  write; cpu_addr  in  BUS_ADDR  address; cpu_wdata  in  BUS_WIDTH  write data.
REQ-004 cpu_rdata  out  BUS_WIDTH  read data; cpu_ready  out  1  one-cycle completion pulse; cpu_err  out  1  fault, valid with cpu_ready.
REQ-005 flush  in  1  invalidate all lines (see Configuration).
REQ-006 Bus-unit side outputs: write_through_req, read_req, read_line_req  1 each; pa  BUS_ADDR; wt_data  BUS_WIDTH.
REQ-007 Bus-unit side inputs: line_data  BUS_WIDTH; addr_count  log2(LINE_SIZE); line_write, cache_entry_refill, trans_rdy, bus_error  1 each.

Function
REQ-008 Address split: offset = addr[6:0], index = addr[10:7], tag = addr[23:11] (defaults); addr[23]=1 is the uncached region.
REQ-009 States: IDLE, LOOKUP, REFILL, WTHRU, UNCACHED, FAULT.
REQ-010 IDLE: on cpu_req, register addr/we/wdata and go to LOOKUP; cpu_req is ignored outside IDLE.
REQ-011 LOOKUP, uncached address: go to UNCACHED, never touching tag or data arrays.
REQ-012 LOOKUP, read hit (valid[index] and tag match): drive cpu_rdata = data[index][offset], pulse cpu_ready, return to IDLE; hit latency is 2 cycles from cpu_req to cpu_ready.
REQ-013 LOOKUP, read miss: go to REFILL.
REQ-014 LOOKUP, write: on hit, update data[index][offset] with wdata in the same cycle; go to WTHRU (write-through, no write-allocate).
REQ-015 REFILL: hold read_line_req=1 with pa = {tag,index,7'b0}.
REQ-016 REFILL: on each line_write, write line_data into data[index][addr_count].
REQ-017 REFILL: valid[index] is cleared on REFILL entry; on cache_entry_refill, set tag[index] and valid[index], then go to LOOKUP, which then hits.
REQ-018 WTHRU: hold write_through_req=1, pa = registered addr, wt_data = wdata; on trans_rdy pulse cpu_ready and go to IDLE.
REQ-019 UNCACHED: hold read_req (read) or write_through_req (write) with pa = registered addr; on trans_rdy, a read returns cpu_rdata = line_data; pulse cpu_ready; go to IDLE.
REQ-020 bus_error in REFILL, WTHRU or UNCACHED: go to FAULT, leaving valid[index] clear.
REQ-021 FAULT: pulse cpu_ready and cpu_err together for one cycle, then go to IDLE.
REQ-022 At most one of the three bus requests is high in any cycle; all three are 0 in IDLE, LOOKUP and FAULT.
REQ-023 cpu_rdata is held from the last completed read until the next completion.

Reset
REQ-024 rst forces IDLE; all valid bits cleared; cpu_ready, cpu_err, all bus requests and cpu_rdata are 0; pa and wt_data are 0.
REQ-025 rst mid-REFILL or mid-WTHRU drops the request in the same cycle, leaves the line invalid, and issues no cpu_ready.
REQ-026 Tag and data arrays are not reset.

Configuration
REQ-027 Macro CACHE_FLUSH_EN, when defined: flush high in IDLE clears every valid bit in one cycle, blocks acceptance of cpu_req that cycle, and has priority over cpu_req.
REQ-028 flush seen outside IDLE is latched and applied on return to IDLE.
REQ-029 Without CACHE_FLUSH_EN, the flush port exists but is ignored.

Structure
REQ-030 Shared package cache_pkg holds the state encoding, the address field widths/positions, and the uncached-region bit.
REQ-031 Sub-module cache_tag_ram: LINES x (tag + valid), combinational read, synchronous write, single-cycle clear-all.
REQ-032 The data array lives in cache_ctrl as a LINES*LINE_SIZE byte array.

Verification
REQ-033 Read 0x000105 after reset -> one read_line_req with pa=0x000100 and 128 line_write beats; cpu_ready carries data[0x05] written by the bus model.
REQ-034 Repeat read 0x000105 -> no bus request; cpu_ready 2 cycles after cpu_req.
REQ-035 Write 0xA5 to 0x000110 (hit) -> write_through_req with pa=0x000110, wt_data=0xA5; a later read of 0x000110 returns 0xA5 with no bus traffic.
REQ-036 Read 0x800004 -> read_req only, pa=0x800004, and no change to valid bits; a second read 0x800004 issues read_req again.
REQ-037 bus_error during refill of 0x000200 -> cpu_ready with cpu_err=1; a retry of 0x000200 issues read_line_req again.
REQ-038 With CACHE_FLUSH_EN: flush after REQ-034 -> next read 0x000105 misses and refills; rst asserted mid-refill -> read_line_req is 0 the next cycle.
